// File: rtl/axis_mcp320x_scan.sv
// axis_mcp320x_scan: SPI scanner for MCP3204/MCP3208-class SAR ADCs.
// Each conversion is one SPI frame. The driver walks the set bits of the
// channel mask, lowest first, and presents every result on a single-register
// AXI4-Stream master. The channel index goes out on tuser, and tlast marks
// the last channel of each scan.
// SPI timing never waits for tready. A result that arrives while the
// previous beat is still held is dropped and counted as an overrun.
module axis_mcp320x_scan #(
   parameter int CHANNELS     = 4,
   parameter int DATA_BITS    = 12,
   parameter int SCLK_DIV     = 10,
   parameter int CS_IDLE_HALF = 2,
   parameter int SNGL_NDIFF   = 1
) (
   input  logic                aclk,
   input  logic                resetn,
   input  logic                enable,
   input  logic [CHANNELS-1:0] channel_mask,
   output logic                busy,
   output logic                overrun,
   output logic [15:0]         overrun_count,
   output logic [15:0]         m_axis_tdata,
   output logic [2:0]          m_axis_tuser,
   output logic                m_axis_tlast,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                spi_sclk,
   output logic                spi_mosi,
   input  logic                spi_miso,
   output logic                spi_ss_n
);

   localparam int             PW         = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(SCLK_DIV - 1);
   localparam logic [4:0]     FRAME_C    = 5'(7 + DATA_BITS);
   localparam logic [4:0]     DATA_LO    = 5'd7;
   localparam logic [4:0]     DATA_HI    = 5'(7 + DATA_BITS);
   localparam logic [15:0]    GAP_LAST   = 16'(CS_IDLE_HALF - 1);
   localparam logic           SGL_BIT    = 1'(SNGL_NDIFF);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, CS_GAP} state_t;

   state_t                state_q;
   logic [PW-1:0]         presc_q;
   logic [4:0]            bitCnt_q;
   logic [15:0]           gapCnt_q;
   logic                  sclk_q;
   logic                  mosi_q;
   logic                  ssN_q;
   logic                  wrap_q;
   logic [CHANNELS-1:0]   maskSnap_q;
   logic [2:0]            ptr_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  overrun_q;
   logic [15:0]           ovCount_q;
   logic [15:0]           tdata_q;
   logic [2:0]            tuser_q;
   logic                  tlast_q;
   logic                  tvalid_q;

   logic                  tick_d;
   logic [2:0]            nextPtr_d;
   logic                  hasNext_d;
   logic [2:0]            firstPtr_d;
   logic                  cmdBit_d;

   // Half-period strobe from the prescaler.
   assign tick_d = (presc_q == PRESC_LAST);

   // Find the next set bit above the current pointer in the snapshotted mask,
   // and the lowest set bit of the live mask for the start of a scan.
   always_comb begin
      nextPtr_d  = '0;
      hasNext_d  = 1'b0;
      firstPtr_d = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (maskSnap_q[i] && (3'(i) > ptr_q)) begin
            nextPtr_d = 3'(i);
            hasNext_d = 1'b1;
         end
         if (channel_mask[i]) begin
            firstPtr_d = 3'(i);
         end
      end
   end

   // Command bit for the next rising edge: start, SGL/DIFF, D2, D1, D0, then zeros.
   always_comb begin
      cmdBit_d = 1'b0;
      case (bitCnt_q + 5'd1)
         5'd1:    cmdBit_d = 1'b1;
         5'd2:    cmdBit_d = SGL_BIT;
         5'd3:    cmdBit_d = (CHANNELS > 4) ? ptr_q[2] : 1'b0;
         5'd4:    cmdBit_d = ptr_q[1];
         5'd5:    cmdBit_d = ptr_q[0];
         default: cmdBit_d = 1'b0;
      endcase
   end

   // Frame sequencer, SPI pins and AXI-Stream output register.
   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         bitCnt_q   <= '0;
         gapCnt_q   <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         ssN_q      <= 1'b1;
         wrap_q     <= 1'b0;
         maskSnap_q <= '0;
         ptr_q      <= '0;
         shift_q    <= '0;
         overrun_q  <= 1'b0;
         ovCount_q  <= '0;
         tdata_q    <= '0;
         tuser_q    <= '0;
         tlast_q    <= 1'b0;
         tvalid_q   <= 1'b0;
      end else begin
         overrun_q <= 1'b0;

         if (state_q == IDLE || state_q == DONE || tick_d) begin
            presc_q <= '0;
         end else begin
            presc_q <= presc_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (enable && (|channel_mask)) begin
                  maskSnap_q <= channel_mask;
                  ptr_q      <= firstPtr_d;
                  ssN_q      <= 1'b0;
                  mosi_q     <= 1'b1;
                  sclk_q     <= 1'b0;
                  state_q    <= SETUP;
               end
            end
            SETUP: begin
               if (tick_d) begin
                  bitCnt_q <= '0;
                  state_q  <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick_d) begin
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                     if (bitCnt_q >= DATA_LO && bitCnt_q < DATA_HI) begin
                        shift_q <= {shift_q[DATA_BITS-2:0], spi_miso};
                     end
                     bitCnt_q <= bitCnt_q + 5'd1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (bitCnt_q == FRAME_C) begin
                        mosi_q  <= 1'b0;
                        state_q <= DONE;
                     end else begin
                        mosi_q <= cmdBit_d;
                     end
                  end
               end
            end
            DONE: begin
               ssN_q    <= 1'b1;
               wrap_q   <= !hasNext_d;
               gapCnt_q <= '0;
               if (hasNext_d) begin
                  ptr_q <= nextPtr_d;
               end
               state_q <= CS_GAP;
            end
            CS_GAP: begin
               if (tick_d) begin
                  if (gapCnt_q == GAP_LAST) begin
                     if (!wrap_q) begin
                        ssN_q   <= 1'b0;
                        mosi_q  <= 1'b1;
                        state_q <= SETUP;
                     end else if (enable && (|channel_mask)) begin
                        maskSnap_q <= channel_mask;
                        ptr_q      <= firstPtr_d;
                        ssN_q      <= 1'b0;
                        mosi_q     <= 1'b1;
                        state_q    <= SETUP;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     gapCnt_q <= gapCnt_q + 16'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase

         if (state_q == DONE) begin
            if (!tvalid_q || m_axis_tready) begin
               tdata_q  <= 16'(shift_q);
               tuser_q  <= ptr_q;
               tlast_q  <= !hasNext_d;
               tvalid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
               if (ovCount_q != 16'hFFFF) begin
                  ovCount_q <= ovCount_q + 16'd1;
               end
            end
         end else if (tvalid_q && m_axis_tready) begin
            tvalid_q <= 1'b0;
         end
      end
   end

   assign busy          = (state_q != IDLE);
   assign overrun       = overrun_q;
   assign overrun_count = ovCount_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tuser  = tuser_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tvalid = tvalid_q;
   assign spi_sclk      = sclk_q;
   assign spi_mosi      = mosi_q;
   assign spi_ss_n      = ssN_q;

endmodule

// File: tb/tb_axis_mcp320x_scan.sv
// Testbench for axis_mcp320x_scan: a default 4-channel instance driven by a
// behavioural ADC model that returns 12'hA5C | channel, plus an 8-channel,
// 10-bit, differential instance whose MISO is held high.
module tb_axis_mcp320x_scan;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic        resetn, enable, busy, overrun, tvalid, tready, tlast;
   logic [3:0]  channelMask;
   logic [15:0] overrunCount, tdata;
   logic [2:0]  tuser;
   logic        sclk, mosi, miso, ssN;

   logic        enable1, busy1, overrun1, tvalid1, tready1, tlast1;
   logic [7:0]  mask1;
   logic [15:0] ovc1, tdata1;
   logic [2:0]  tuser1;
   logic        sclk1, mosi1, ssN1;
   logic        miso1 = 1'b1;

   int checks = 0;
   int errors = 0;

   axis_mcp320x_scan dut0 (
      .aclk(aclk), .resetn(resetn), .enable(enable), .channel_mask(channelMask),
      .busy(busy), .overrun(overrun), .overrun_count(overrunCount),
      .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .spi_sclk(sclk), .spi_mosi(mosi), .spi_miso(miso), .spi_ss_n(ssN));

   axis_mcp320x_scan #(.CHANNELS(8), .DATA_BITS(10), .SNGL_NDIFF(0)) dut1 (
      .aclk(aclk), .resetn(resetn), .enable(enable1), .channel_mask(mask1),
      .busy(busy1), .overrun(overrun1), .overrun_count(ovc1),
      .m_axis_tdata(tdata1), .m_axis_tuser(tuser1), .m_axis_tlast(tlast1),
      .m_axis_tvalid(tvalid1), .m_axis_tready(tready1),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1), .spi_ss_n(ssN1));

   // ADC model: decodes the 5 command bits, then shifts out 12'hA5C|ch on falling edges.
   int          riseCnt = 0;
   int          fallCnt = 0;
   logic [4:0]  cmdSh = '0;
   logic [4:0]  cmdHist [8];
   logic [7:0]  selSeen = '0;
   logic [11:0] adcWord;

   always @(negedge ssN) begin
      riseCnt = 0;
      fallCnt = 0;
      cmdSh   = '0;
   end

   always @(posedge sclk) begin
      if (!ssN) begin
         riseCnt++;
         if (riseCnt <= 5) cmdSh = {cmdSh[3:0], mosi};
         if (riseCnt == 5) begin
            cmdHist[cmdSh[2:0]] = cmdSh;
            selSeen[cmdSh[2:0]] = 1'b1;
         end
      end
   end

   always @(negedge sclk) begin
      if (!ssN) begin
         fallCnt++;
         adcWord = 12'hA5C | {9'd0, cmdSh[2:0]};
         if (fallCnt >= 7 && fallCnt < 19) miso = adcWord[18-fallCnt];
         else miso = 1'b0;
      end
   end

   // Waits for one accepted beat on dut0, zeros on timeout.
   task automatic waitBeat(output logic ok, output logic [15:0] d, output logic [2:0] u, output logic l);
      ok = 1'b0; d = '0; u = '0; l = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge aclk);
         if (tvalid && tready) begin
            ok = 1'b1; d = tdata; u = tuser; l = tlast;
            break;
         end
      end
   endtask

   // Waits until dut0 returns to idle.
   task automatic waitIdle(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge aclk);
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic waitSsLow(output logic ok);
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge aclk);
         if (!ssN) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({ssN, sclk, mosi, busy, overrun, tvalid, tlast} !== 7'b1000000) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got ss/sclk/mosi/busy/ovr/valid/last=%b want 1000000",
                  {ssN, sclk, mosi, busy, overrun, tvalid, tlast});
      end
      checks++;
      if ({overrunCount, tdata, tuser} !== 35'd0) begin
         errors++;
         $display("[TB] FAIL reset_data got count=%h tdata=%h tuser=%0d want 0", overrunCount, tdata, tuser);
      end
      checks++;
      if ({ssN1, tvalid1, busy1} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL reset_dut1 got ss/valid/busy=%b want 100", {ssN1, tvalid1, busy1});
      end
      resetn = 1'b1;
   endtask

   task automatic test_full_scan;
      logic ok; logic [15:0] d; logic [2:0] u; logic l;
      channelMask = 4'b1111; tready = 1'b1; enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         waitBeat(ok, d, u, l);
         checks++;
         if (!ok || d !== 16'h0A5C + 16'(i) || u !== 3'(i) || l !== (i == 3)) begin
            errors++;
            $display("[TB] FAIL full_scan beat%0d got ok=%b tdata=%h tuser=%0d tlast=%b want tdata=%h tuser=%0d tlast=%b",
                     i, ok, d, u, l, 16'h0A5C + 16'(i), i, (i == 3));
         end
      end
      enable = 1'b0;
      waitIdle(ok);
      checks++;
      if (cmdHist[2] !== 5'b11010) begin
         errors++;
         $display("[TB] FAIL cmd_ch2 got %b want 11010", cmdHist[2]);
      end
   endtask

   task automatic test_mask_sparse;
      logic ok; logic [15:0] d; logic [2:0] u; logic l;
      logic [2:0] expU;
      selSeen = '0;
      channelMask = 4'b0101; enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expU = (i % 2 == 0) ? 3'd0 : 3'd2;
         waitBeat(ok, d, u, l);
         if (i == 3) enable = 1'b0;
         checks++;
         if (!ok || u !== expU || l !== (expU == 3'd2) || d !== (16'h0A5C | 16'(expU))) begin
            errors++;
            $display("[TB] FAIL sparse beat%0d got tuser=%0d tlast=%b tdata=%h want tuser=%0d tlast=%b tdata=%h",
                     i, u, l, d, expU, (expU == 3'd2), 16'h0A5C | 16'(expU));
         end
      end
      waitIdle(ok);
      checks++;
      if (!ok || selSeen !== 8'h05) begin
         errors++;
         $display("[TB] FAIL sparse_sel got channels=%b want 00000101", selSeen);
      end
   endtask

   task automatic test_overrun;
      logic ok;
      int pulses = 0;
      int unstable = 0;
      channelMask = 4'b0001; tready = 1'b0; enable = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge aclk);
         if (tvalid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok || tdata !== 16'h0A5C || tuser !== 3'd0 || tlast !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovr_first got valid=%b tdata=%h tuser=%0d tlast=%b want 1 0a5c 0 1", ok, tdata, tuser, tlast);
      end
      for (int n = 0; n < 4000 && busy; n++) begin
         @(negedge aclk);
         if (overrun) pulses++;
         if (pulses == 2) enable = 1'b0;
         if (tvalid !== 1'b1 || tdata !== 16'h0A5C || tuser !== 3'd0 || tlast !== 1'b1) unstable++;
      end
      checks++;
      if (pulses != 2 || overrunCount !== 16'd2) begin
         errors++;
         $display("[TB] FAIL ovr_count got pulses=%0d count=%0d want 2 2", pulses, overrunCount);
      end
      checks++;
      if (unstable != 0 || busy) begin
         errors++;
         $display("[TB] FAIL ovr_hold got unstable=%0d busy=%b want 0 0", unstable, busy);
      end
      tready = 1'b1;
      @(negedge aclk);
      checks++;
      if (tvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovr_drain got tvalid=%b want 0", tvalid);
      end
   endtask

   task automatic test_enable_drop;
      logic ok; logic [15:0] d; logic [2:0] u; logic l;
      int bad = 0;
      channelMask = 4'b1111; tready = 1'b1; enable = 1'b1;
      waitBeat(ok, d, u, l);
      waitSsLow(ok);
      enable = 1'b0;
      for (int i = 1; i < 4; i++) begin
         waitBeat(ok, d, u, l);
         checks++;
         if (!ok || u !== 3'(i) || l !== (i == 3) || d !== 16'h0A5C + 16'(i)) begin
            errors++;
            $display("[TB] FAIL endrop beat%0d got tuser=%0d tlast=%b tdata=%h want tuser=%0d", i, u, l, d, i);
         end
      end
      waitIdle(ok);
      for (int n = 0; n < 1000; n++) begin
         @(negedge aclk);
         if (busy || !ssN) bad++;
      end
      checks++;
      if (!ok || bad != 0) begin
         errors++;
         $display("[TB] FAIL endrop_idle got bad_cycles=%0d want 0", bad);
      end
      bad = 0;
      channelMask = 4'b0000; enable = 1'b1;
      for (int n = 0; n < 500; n++) begin
         @(negedge aclk);
         if (busy || !ssN) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL zero_mask got active_cycles=%0d want 0", bad);
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic ok; logic [15:0] d; logic [2:0] u; logic l;
      channelMask = 4'b0110; tready = 1'b0; enable = 1'b1;
      for (int n = 0; n < 3000 && !tvalid; n++) @(negedge aclk);
      waitSsLow(ok);
      repeat (150) @(negedge aclk);
      resetn = 1'b0;
      @(posedge aclk);
      #1;
      checks++;
      if ({ssN, sclk, tvalid, busy} !== 4'b1000 || overrunCount !== 16'd0) begin
         errors++;
         $display("[TB] FAIL midreset got ss/sclk/valid/busy=%b count=%0d want 1000 0", {ssN, sclk, tvalid, busy}, overrunCount);
      end
      @(negedge aclk);
      resetn = 1'b1;
      tready = 1'b1;
      waitBeat(ok, d, u, l);
      checks++;
      if (!ok || u !== 3'd1 || d !== 16'h0A5D || l !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_b0 got tuser=%0d tdata=%h tlast=%b want 1 0a5d 0", u, d, l);
      end
      waitBeat(ok, d, u, l);
      enable = 1'b0;
      checks++;
      if (!ok || u !== 3'd2 || d !== 16'h0A5E || l !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_b1 got tuser=%0d tdata=%h tlast=%b want 2 0a5e 1", u, d, l);
      end
      waitIdle(ok);
   endtask

   task automatic test_diff8;
      logic [4:0] cmd = '0;
      int nb = 0;
      logic prev = 1'b0;
      logic got = 1'b0;
      mask1 = 8'h80; enable1 = 1'b1;
      for (int n = 0; n < 3000 && !got; n++) begin
         @(negedge aclk);
         if (sclk1 && !prev && nb < 5) begin
            cmd = {cmd[3:0], mosi1};
            nb++;
         end
         prev = sclk1;
         if (tvalid1) got = 1'b1;
      end
      enable1 = 1'b0;
      checks++;
      if (nb != 5 || cmd !== 5'b10111) begin
         errors++;
         $display("[TB] FAIL diff8_cmd got %b (%0d bits) want 10111", cmd, nb);
      end
      checks++;
      if (!got || tdata1 !== 16'h03FF || tuser1 !== 3'd7 || tlast1 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL diff8_beat got tdata=%h tuser=%0d tlast=%b want 03ff 7 1", tdata1, tuser1, tlast1);
      end
      for (int n = 0; n < 3000 && busy1; n++) @(negedge aclk);
   endtask

   initial begin
      resetn = 1'b0; enable = 1'b0; channelMask = '0; tready = 1'b1; miso = 1'b0;
      enable1 = 1'b0; mask1 = '0; tready1 = 1'b1;
      for (int i = 0; i < 8; i++) cmdHist[i] = '0;
      test_reset;
      test_full_scan;
      test_mask_sparse;
      test_overrun;
      test_enable_drop;
      test_reset_mid;
      test_diff8;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
